// File: rtl/adder_tree_sched.sv
// Credit-gated round-robin scheduler feeding a shared 2-stage adder tree and a result FIFO.
// `define ADDER_TREE_SCHED_FULL_TREE_EN sums all 8 operands; otherwise only operands 0..3 are summed.
module adder_tree_sched_lvl #(
  parameter int N  = 4,
  parameter int IW = 21
) (
  input  logic [2*N-1:0][IW-1:0] din,
  output logic [N-1:0][IW:0]     dout
);
  for (genvar p = 0; p < N; p++) begin : g_pair
    assign dout[p] = {1'b0, din[2*p]} + {1'b0, din[2*p+1]};
  end
endmodule

module adder_tree_sched #(
  parameter int ADDER_WIDTH = 21,
  parameter int NREQ        = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_W        = 2,
`ifdef ADDER_TREE_SCHED_FULL_TREE_EN
  localparam int LV         = 3,
`else
  localparam int LV         = 2,
`endif
  localparam int OUT_W      = ADDER_WIDTH + LV
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sched_en,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*8*ADDER_WIDTH-1:0]   req_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [OUT_W-1:0]                res_sum,
  output logic [ID_W-1:0]                 res_id,
  output logic                            busy
);
  localparam int NOPS   = 1 << LV;
  localparam int STAGES = 2;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 2;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic [ID_W-1:0]  id;
  } res_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FULL} state_t;

  logic [NREQ-1:0][7:0][ADDER_WIDTH-1:0] ops;
  logic [ID_W-1:0]   ptr, gnt_idx;
  logic              gnt_found, issue_ok, transfer;
  logic [STAGES:1]   vld_pipe;
  logic [AW:0]       count;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     used;
  logic              push, pop;
  state_t            state;
  res_t              mem [FIFO_DEPTH];

  logic [NOPS-1:0][ADDER_WIDTH-1:0] s0_ops;
  logic [ID_W-1:0]                  s0_id, s1_id;
  logic [OUT_W-1:0]                 s1_sum, root;

  assign ops  = req_data;
  assign used = CW'(count) + CW'(vld_pipe[1]) + CW'(vld_pipe[2]);
  assign busy = (used != '0);

  // Every issued request reserves a FIFO slot until it is popped, so pushes always find room.
  always_comb begin
    state = IDLE;
    if (!sched_en)                       state = (used == '0) ? IDLE : DRAIN;
    else if (used >= CW'(FIFO_DEPTH))    state = FULL;
    else if (used == '0 && req_valid == '0) state = IDLE;
    else                                 state = RUN;
  end

  assign issue_ok = !rst && sched_en && (state != FULL);

  always_comb begin : arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign transfer  = issue_ok && gnt_found;
  assign req_ready = transfer ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ptr      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], transfer};
      if (transfer) ptr <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (transfer) begin
      s0_ops <= ops[gnt_idx][NOPS-1:0];
      s0_id  <= gnt_idx;
    end
    s1_sum <= root;
    s1_id  <= s0_id;
  end

  logic [NOPS/2-1:0][ADDER_WIDTH:0]   lvl1;
  logic [NOPS/4-1:0][ADDER_WIDTH+1:0] lvl2;

  adder_tree_sched_lvl #(.N(NOPS/2), .IW(ADDER_WIDTH))   u_lvl1 (.din(s0_ops), .dout(lvl1));
  adder_tree_sched_lvl #(.N(NOPS/4), .IW(ADDER_WIDTH+1)) u_lvl2 (.din(lvl1),   .dout(lvl2));

`ifdef ADDER_TREE_SCHED_FULL_TREE_EN
  logic [0:0][ADDER_WIDTH+2:0] lvl3;
  adder_tree_sched_lvl #(.N(1), .IW(ADDER_WIDTH+2)) u_lvl3 (.din(lvl2), .dout(lvl3));
  assign root = lvl3[0];
`else
  assign root = lvl2[0];
  // Operands 4..7 are deliberately ignored by the half tree.
  logic unused_hi;
  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < NREQ; i++) unused_hi = unused_hi ^ (^ops[i][7:NOPS]);
  end
`endif

  assign push      = vld_pipe[STAGES];
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_sum   = mem[rd_ptr].sum;
  assign res_id    = mem[rd_ptr].id;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{sum: s1_sum, id: s1_id};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: latency, round-robin order, credit stall, drain and reset.
module tb_adder_tree_sched;
  localparam int W     = 21;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
`ifdef ADDER_TREE_SCHED_FULL_TREE_EN
  localparam int OUT_W    = W + 3;
  localparam int SUM_STEP = 800;
  localparam int SUM_BASE = 36;
  localparam int MAXSUM   = 16777208;
`else
  localparam int OUT_W    = W + 2;
  localparam int SUM_STEP = 400;
  localparam int SUM_BASE = 10;
  localparam int MAXSUM   = 8388604;
`endif

  logic                    clk = 1'b0;
  logic                    rst, sched_en, res_ready;
  logic [NREQ-1:0]         req_valid, req_ready;
  logic [NREQ*8*W-1:0]     req_data;
  logic                    res_valid, busy;
  logic [OUT_W-1:0]        res_sum;
  logic [1:0]              res_id;

  int n_chk  = 0;
  int n_pass = 0;

  adder_tree_sched dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Requester r, operand k = r*100 + k + 1.
  task automatic fill_pattern();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++)
        req_data[(r*8+k)*W +: W] = W'(r*100 + k + 1);
  endtask

  task automatic wait_res(input string tag, input int max);
    for (int i = 0; i < max && !res_valid; i++) tick();
    check(tag, 32'(res_valid), 1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && busy; i++) tick();
    check(tag, 32'(busy), 0);
  endtask

  always @(negedge clk)
    if (!rst && dut.push) check("push_room", 32'(int'(dut.count) < DEPTH), 1);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ids [16];
    rst = 1; sched_en = 0; req_valid = '0; res_ready = 0; req_data = '0;
    fill_pattern();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_sum",   32'(res_sum),   0);
    check("rst_id",    32'(res_id),    0);
    check("rst_busy",  32'(busy),      0);
    rst = 0;

    // Single request: latency 2, one-cycle result.
    sched_en = 1; res_ready = 1; req_valid = 4'b0001;
    #1 check("t1_ready", 32'(req_ready), 1);
    tick(); req_valid = '0;
    #1 check("t1_lat0", 32'(res_valid), 0);
    tick(); check("t1_lat1", 32'(res_valid), 0);
    tick();
    check("t1_valid", 32'(res_valid), 1);
    check("t1_sum",   32'(res_sum),   SUM_BASE);
    check("t1_id",    32'(res_id),    0);
    tick();
    check("t1_width", 32'(res_valid), 0);
    check("t1_busy",  32'(busy),      0);

    rst = 1; tick(); rst = 0;

    // Round robin at full rate.
    req_valid = '1;
    for (int p = 0; p < 9; p++) begin
      if (p == 6) req_valid = '0;
      #1;
      check("t2_grant", 32'(req_ready), (p < 6) ? (32'(1) << (p % 4)) : 0);
      if (p >= 3) begin
        check("t2_valid", 32'(res_valid), 1);
        check("t2_id",    32'(res_id),    (p - 3) % 4);
        check("t2_sum",   32'(res_sum),   SUM_STEP * ((p - 3) % 4) + SUM_BASE);
      end
      tick();
    end
    check("t2_empty", 32'(res_valid), 0);
    check("t2_idle",  32'(busy),      0);

    // Credit exhaustion with downstream stalled.
    res_ready = 0; req_valid = '1; n = 0;
    for (int p = 0; p < 8; p++) begin
      #1 if (req_ready != '0) n++;
      tick();
    end
    check("t3_xfers", n, 4);
    check("t3_full",  32'(req_ready), 0);
    check("t3_head",  32'(res_id),    2);
    res_ready = 1;
    tick(); res_ready = 0;
    #1 check("t3_regrant", 32'(req_ready), 4'b0100);
    tick();
    check("t3_refull", 32'(req_ready), 0);
    req_valid = '0; res_ready = 1;
    wait_idle("t3_drain", 20);

    // Maximum operands: no overflow.
    for (int k = 0; k < 8; k++) req_data[(1*8+k)*W +: W] = '1;
    req_valid = 4'b0010;
    #1 check("t4_ready", 32'(req_ready), 4'b0010);
    tick(); req_valid = '0;
    wait_res("t4_valid", 8);
    check("t4_sum", 32'(res_sum), MAXSUM);
    check("t4_id",  32'(res_id),  1);
    tick();
    fill_pattern();

    // Scheduler disable after two grants; in-flight work still drains.
    req_valid = '1;
    #1 check("t5_g0", 32'(req_ready), 4'b0100);
    tick();
    check("t5_g1", 32'(req_ready), 4'b1000);
    tick(); sched_en = 0;
    #1 check("t5_stop", 32'(req_ready), 0);
    check("t5_busy", 32'(busy), 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (res_valid && n < 16) begin ids[n] = res_id; n++; end
      tick();
    end
    check("t5_count", n, 2);
    check("t5_id0",   ids[0], 2);
    check("t5_id1",   ids[1], 3);
    check("t5_stay",  32'(req_ready), 0);
    check("t5_idle",  32'(busy), 0);

    // Reset with two results buffered and two in flight.
    sched_en = 1; res_ready = 0; req_valid = 4'b0110;
    repeat (4) tick();
    check("t6_pre_valid", 32'(res_valid), 1);
    check("t6_pre_busy",  32'(busy), 1);
    rst = 1;
    tick();
    check("t6_valid", 32'(res_valid), 0);
    check("t6_busy",  32'(busy), 0);
    check("t6_hold",  32'(req_ready), 0);
    rst = 0; req_valid = '1;
    #1 check("t6_first", 32'(req_ready), 4'b0001);
    tick(); req_valid = '0; res_ready = 1;
    wait_res("t6_res", 8);
    check("t6_id",  32'(res_id),  0);
    check("t6_sum", 32'(res_sum), SUM_BASE);
    tick();
    check("t6_nostale", 32'(res_valid), 0);
    wait_idle("t6_idle", 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
